// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: BEOp encodings, default depth
// and the packed layout of one buffered store entry.
package store_buffer_pkg;

    typedef enum logic [1:0] {
        BE_WORD = 2'b00,
        BE_HALF = 2'b01,
        BE_BYTE = 2'b10,
        BE_RSVD = 2'b11
    } be_op_e;

    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// Store alignment: lane byte-enables, replicated write data and
// misalign detection. Ports: st_valid/addr/data/beop in; be/wdata/misalign out.
import store_buffer_pkg::*;

module store_align (
    input  logic        st_valid,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [1:0]  beop,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign
);

    logic bad;

    always_comb begin
        be    = 4'b0000;
        wdata = data;
        bad   = 1'b0;
        case (be_op_e'(beop))
            BE_WORD: begin
                be  = 4'b1111;
                bad = (addr[1:0] != 2'b00);
            end
            BE_HALF: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data[15:0]}};
                bad   = addr[0];
            end
            BE_BYTE: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{data[7:0]}};
            end
            default: bad = 1'b1;
        endcase
        misalign = st_valid && bad;
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between M stage and data memory with optional
// load/store word-overlap detection (enabled by STORE_BUFFER_HAZARD_EN).
// Ports: st_* enqueue side, mem_* drain side, ld_addr/ld_hazard, count.
import store_buffer_pkg::*;

module store_buffer #(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [31:0]            st_addr,
    input  logic [31:0]            st_data,
    input  logic [1:0]             st_beop,
    output logic                   st_misalign,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_be,
    input  logic [31:0]            ld_addr,
    output logic                   ld_hazard,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t       ent_q [DEPTH];
    sb_entry_t       new_ent;
    sb_entry_t       head;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      al_be;
    logic [31:0]     al_wdata;
    logic            enq, deq;

    store_align u_align (
        .st_valid (st_valid),
        .addr     (st_addr),
        .data     (st_data),
        .beop     (st_beop),
        .be       (al_be),
        .wdata    (al_wdata),
        .misalign (st_misalign)
    );

    assign st_ready  = (count_q != CW'(DEPTH));
    assign mem_valid = (count_q != '0);
    assign enq       = st_valid && st_ready && !st_misalign;
    assign deq       = mem_valid && mem_ready;
    assign count     = count_q;

    assign new_ent = '{waddr: st_addr[31:2], data: al_wdata, be: al_be};
    assign head    = ent_q[rd_ptr_q];

    assign mem_addr  = {head.waddr, 2'b00};
    assign mem_wdata = head.data;
    assign mem_be    = head.be;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
        if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload is deliberately left unreset; it is only observed when valid.
    always_ff @(posedge clk) begin
        if (enq) ent_q[wr_ptr_q] <= new_ent;
    end

`ifdef STORE_BUFFER_HAZARD_EN
    logic       hz;
    logic [1:0] unused_ld;

    assign unused_ld = ld_addr[1:0];

    // An entry is live when its distance from the head is below count.
    always_comb begin : hz_cmp
        logic [PW-1:0] off;
        hz = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (({1'b0, off} < count_q) &&
                (ent_q[i].waddr == ld_addr[31:2]))
                hz = 1'b1;
        end
    end

    assign ld_hazard = hz;
`else
    logic unused_ld;

    assign unused_ld = ^ld_addr;
    assign ld_hazard = 1'b0;
`endif

endmodule
